// File: rtl/programmable_clock_divider.sv
`default_nettype none
// ============================================================================
// Module  : programmable_clock_divider
// Brief   : Runtime-loadable divide-by-N clock divider with tick strobe and
//           period-boundary divisor updates.
// Revision: 1.0 - initial release
// ============================================================================
module programmable_clock_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             clk_in_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o,
  output logic [WIDTH-1:0] cur_div_o
);

  localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] C_MIN_DIV     = WIDTH'(2);
  localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] div_clamped;
  logic             boundary;
  logic [WIDTH-1:0] next_phase;
  logic [WIDTH:0]   next_half;

  always_comb begin
    div_clamped = (div_i < C_MIN_DIV) ? C_MIN_DIV : div_i;
    boundary    = en_i && (cnt_q == '0);

    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    tick_d     = 1'b0;

    if (boundary) begin
      // A load on the boundary edge beats any older pending divisor.
      if (load_i) begin
        cur_div_d = div_clamped;
      end else if (pending_q) begin
        cur_div_d = pend_div_q;
      end
      cnt_d     = cur_div_d - C_ONE;
      pending_d = 1'b0;
    end else begin
      if (en_i) begin
        cnt_d  = cnt_q - C_ONE;
        tick_d = (cnt_d == '0);
      end
      if (load_i) begin
        pend_div_d = div_clamped;
        pending_d  = 1'b1;
      end
    end

    // Output level is derived from the phase being entered, so it is registered.
    next_phase = cur_div_d - C_ONE - cnt_d;
    next_half  = ({1'b0, cur_div_d} + (WIDTH+1)'(1)) >> 1;
    clk_out_d  = ({1'b0, next_phase} < next_half);
  end

  always_ff @(posedge clk_in_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= C_DEFAULT_DIV - C_ONE;
      cur_div_q  <= C_DEFAULT_DIV;
      pend_div_q <= C_DEFAULT_DIV;
      pending_q  <= 1'b0;
      clk_out_q  <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;
  assign cur_div_o = cur_div_q;

endmodule
`default_nettype wire

// File: tb/tb_programmable_clock_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_programmable_clock_divider
// Brief   : Randomised and directed bench against a phase-based divider model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_programmable_clock_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] div = '0;
  logic             clk_out, tick, pending;
  logic [WIDTH-1:0] cur_div;

  int checks = 0;
  int errors = 0;

  programmable_clock_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(50)) dut (
    .clk_in_i (clk),
    .rst_i    (rst),
    .en_i     (en),
    .load_i   (load),
    .div_i    (div),
    .clk_out_o(clk_out),
    .tick_o   (tick),
    .pending_o(pending),
    .cur_div_o(cur_div)
  );

  always #5 clk = ~clk;

  // Model state: phase counts upward 0..N-1 within the current period.
  int m_n, m_phase, m_pend_val;
  bit m_pend, m_tick;

  function automatic int clampv(int v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 50; m_phase = 0; m_pend = 0; m_pend_val = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (en && m_phase == m_n - 1) begin
        if (load) m_n = clampv(int'(div));
        else if (m_pend) m_n = m_pend_val;
        m_pend  = 0;
        m_phase = 0;
      end else begin
        if (en) begin
          m_phase = m_phase + 1;
          m_tick  = (m_phase == m_n - 1);
        end
        if (load) begin
          m_pend_val = clampv(int'(div));
          m_pend     = 1;
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("clk_out", int'(clk_out), int'(m_phase < (m_n + 1) / 2));
    chk("tick", int'(tick), int'(m_tick));
    chk("pending", int'(pending), int'(m_pend));
    chk("cur_div", int'(cur_div), m_n);
  end

  task automatic step(bit e, bit l, int d);
    en = e; load = l; div = WIDTH'(d);
    @(posedge clk); #1;
  endtask

  // Pulse reset between edges, starting 1 time unit after a rising edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    chk("rst_clk_out", int'(clk_out), 1);
    chk("rst_pending", int'(pending), 0);
    chk("rst_cur_div", int'(cur_div), 50);
    chk("rst_tick", int'(tick), 0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int first_tick;
    #2; rst = 1'b1; #6; rst = 1'b0;
    @(posedge clk); #1;
    chk("init_cur_div", int'(cur_div), 50);
    chk("init_clk_out", int'(clk_out), 1);

    // Default period: ticks at cycle 49, boundary at 50 with an immediate load of 5.
    for (int i = 0; i < 24; i++) step(1, 0, 0);
    chk("c24_clk", int'(clk_out), 1);
    step(1, 0, 0);
    chk("c25_clk", int'(clk_out), 0);
    for (int i = 0; i < 24; i++) step(1, 0, 0);
    chk("c49_tick", int'(tick), 1);
    step(1, 1, 5);
    chk("load5_cur", int'(cur_div), 5);
    chk("load5_pend", int'(pending), 0);
    chk("load5_p0", int'(clk_out), 1);
    step(1, 0, 0); step(1, 0, 0);
    chk("load5_p2", int'(clk_out), 1);
    step(1, 0, 0);
    chk("load5_p3", int'(clk_out), 0);
    step(1, 0, 0);
    chk("load5_tick", int'(tick), 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    // Mid-period load of 4 with N=50.
    pulse_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    step(1, 1, 4);
    chk("mid_pend", int'(pending), 1);
    chk("mid_cur", int'(cur_div), 50);
    for (int i = 0; i < 38; i++) step(1, 0, 0);
    chk("mid_c49_tick", int'(tick), 1);
    step(1, 0, 0);
    chk("mid_c50_cur", int'(cur_div), 4);
    chk("mid_c50_pend", int'(pending), 0);

    // Clamp and overwrite: 0 then 1, both stored as 2.
    step(1, 1, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("clamp_cur", int'(cur_div), 2);
    chk("clamp_hi", int'(clk_out), 1);
    step(1, 0, 0);
    chk("clamp_lo", int'(clk_out), 0);

    // Enable gap of 7 cycles at phase 20 moves the tick to cycle 56.
    pulse_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    first_tick = -1;
    for (int c = 28; c <= 120 && first_tick < 0; c++) begin
      step(1, 0, 0);
      if (tick) first_tick = c;
    end
    chk("en_gap_tick_cycle", first_tick, 56);

    // Reset mid-period with a pending divisor.
    pulse_reset();
    for (int i = 0; i < 30; i++) step(1, 0, 0);
    step(1, 1, 7);
    chk("pre_rst_pend", int'(pending), 1);
    pulse_reset();
    for (int i = 0; i < 49; i++) step(1, 0, 0);
    chk("post_rst_tick", int'(tick), 1);

    // Randomised traffic, biased toward short divisors.
    for (int i = 0; i < 4000; i++) begin
      int d;
      d = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 9));
      if ($urandom_range(0, 399) == 0) pulse_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
